// File: rtl/wb_arbiter_pkg.sv
// Shared types and width defaults for the write-back arbiter slice.
package wb_arbiter_pkg;

  // Register-file widths used by the pipeline (data and address).
  localparam int unsigned DEF_REG_SIZE = 32;
  localparam int unsigned DEF_REG_ADDR = 5;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_ALU    = 2'd1,
    SRC_BUF    = 2'd2,
    SRC_BYPASS = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus between the ALU/multiply pipeline, decode and the arbiter.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned REG_SIZE = DEF_REG_SIZE,
  parameter int unsigned REG_ADDR = DEF_REG_ADDR
);
  logic                alu_regwrite_in;
  logic [REG_ADDR-1:0] alu_wreg_in;
  logic [REG_SIZE-1:0] alu_result_in;
  logic                mult_regwrite_in;
  logic [REG_ADDR-1:0] mult_wreg_in;
  logic [REG_SIZE-1:0] mult_result_in;
  logic [REG_ADDR-1:0] rd_addr_a;
  logic [REG_ADDR-1:0] rd_addr_b;
  logic                rf_we;
  logic [REG_ADDR-1:0] rf_waddr;
  logic [REG_SIZE-1:0] rf_wdata;
  logic                mult_stall;
  logic                hazard_a;
  logic                hazard_b;
  logic                overflow_err;

  // Pipeline / decode side.
  modport master (
    output alu_regwrite_in, alu_wreg_in, alu_result_in,
    output mult_regwrite_in, mult_wreg_in, mult_result_in,
    output rd_addr_a, rd_addr_b,
    input  rf_we, rf_waddr, rf_wdata,
    input  mult_stall, hazard_a, hazard_b, overflow_err
  );

  // Arbiter side.
  modport slave (
    input  alu_regwrite_in, alu_wreg_in, alu_result_in,
    input  mult_regwrite_in, mult_wreg_in, mult_result_in,
    input  rd_addr_a, rd_addr_b,
    output rf_we, rf_waddr, rf_wdata,
    output mult_stall, hazard_a, hazard_b, overflow_err
  );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: in-order buffer of multiply results waiting for the write port.
// Each entry carries a live bit so younger ALU writes can cancel it in place.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned REG_SIZE = DEF_REG_SIZE,
  parameter int unsigned REG_ADDR = DEF_REG_ADDR,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned PW      = $clog2(DEPTH),
  localparam int unsigned CW      = PW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [REG_ADDR-1:0] push_wreg,
  input  logic [REG_SIZE-1:0] push_data,
  input  logic                pop,
  input  logic                kill_en,
  input  logic [REG_ADDR-1:0] kill_wreg,
  input  logic [REG_ADDR-1:0] match_a_addr,
  input  logic [REG_ADDR-1:0] match_b_addr,
  output logic                head_live,
  output logic [REG_ADDR-1:0] head_wreg,
  output logic [REG_SIZE-1:0] head_data,
  output logic                empty,
  output logic [CW-1:0]       count,
  output logic                match_a,
  output logic                match_b
);

  logic [DEPTH-1:0]    live;
  logic [REG_ADDR-1:0] wreg_q [DEPTH];
  logic [REG_SIZE-1:0] data_q [DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;

  // Pointers, occupancy and live bits. Kill sees pre-edge contents; a pop
  // clears the freed slot, and a push into that same slot overrides it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_en && (wreg_q[i] == kill_wreg)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[head] <= 1'b0;
        head       <= head + PW'(1);
      end
      if (push) begin
        live[tail] <= 1'b1;
        tail       <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; validity is tracked solely by the live bits.
  always_ff @(posedge clk) begin
    if (push) begin
      wreg_q[tail] <= push_wreg;
      data_q[tail] <= push_data;
    end
  end

  // Head view and source-register match against live entries.
  always_comb begin
    head_live = live[head];
    head_wreg = wreg_q[head];
    head_data = data_q[head];
    empty     = (count == '0);
    match_a   = 1'b0;
    match_b   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live[i] && (wreg_q[i] == match_a_addr)) match_a = 1'b1;
      if (live[i] && (wreg_q[i] == match_b_addr)) match_b = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and multiply write-backs onto the single register
// file write port, buffering multiply results that lose arbitration.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned REG_SIZE = DEF_REG_SIZE,
  parameter int unsigned REG_ADDR = DEF_REG_ADDR,
  parameter int unsigned DEPTH    = 4
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  wb_src_e             src;
  logic                alu_v;
  logic                mult_v;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                drop;
  logic                head_live;
  logic [REG_ADDR-1:0] head_wreg;
  logic [REG_SIZE-1:0] head_data;
  logic                empty;
  logic [CW-1:0]       count;
  logic                match_a;
  logic                match_b;
  logic                ovf_q;

  wb_fifo #(
    .REG_SIZE (REG_SIZE),
    .REG_ADDR (REG_ADDR),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_wreg    (bus.mult_wreg_in),
    .push_data    (bus.mult_result_in),
    .pop          (pop),
    .kill_en      (alu_v),
    .kill_wreg    (bus.alu_wreg_in),
    .match_a_addr (bus.rd_addr_a),
    .match_b_addr (bus.rd_addr_b),
    .head_live    (head_live),
    .head_wreg    (head_wreg),
    .head_data    (head_data),
    .empty        (empty),
    .count        (count),
    .match_a      (match_a),
    .match_b      (match_b)
  );

  // Port arbitration: ALU, then live buffer head, then multiply bypass.
  // A multiply colliding with a same-cycle ALU write to the same register
  // is older and would be overwritten anyway, so it is dropped on entry.
  always_comb begin
    alu_v    = bus.alu_regwrite_in && (bus.alu_wreg_in != '0);
    mult_v   = bus.mult_regwrite_in && (bus.mult_wreg_in != '0) &&
               !(alu_v && (bus.alu_wreg_in == bus.mult_wreg_in));
    src      = SRC_NONE;
    if (alu_v)                   src = SRC_ALU;
    else if (!empty && head_live) src = SRC_BUF;
    else if (mult_v && empty)     src = SRC_BYPASS;
    pop      = !empty && (!head_live || (src == SRC_BUF));
    push_req = mult_v && (src != SRC_BYPASS);
    push     = push_req && ((count != FULL_CNT) || pop);
    drop     = push_req && (count == FULL_CNT) && !pop;
  end

  // Registered write port and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      ovf_q        <= 1'b0;
    end else begin
      bus.rf_we <= (src != SRC_NONE);
      case (src)
        SRC_ALU: begin
          bus.rf_waddr <= bus.alu_wreg_in;
          bus.rf_wdata <= bus.alu_result_in;
        end
        SRC_BUF: begin
          bus.rf_waddr <= head_wreg;
          bus.rf_wdata <= head_data;
        end
        SRC_BYPASS: begin
          bus.rf_waddr <= bus.mult_wreg_in;
          bus.rf_wdata <= bus.mult_result_in;
        end
        default: ;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Stall and hazard outputs from registered buffer state.
  always_comb begin
    bus.overflow_err = ovf_q;
    bus.mult_stall   = (count >= STALL_CNT);
    bus.hazard_a     = (bus.rd_addr_a != '0) && match_a;
    bus.hazard_b     = (bus.rd_addr_b != '0) && match_b;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH = 4).
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  wb_arbiter_if #(.REG_SIZE(32), .REG_ADDR(5)) bus ();

  wb_arbiter #(.REG_SIZE(32), .REG_ADDR(5), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.alu_regwrite_in  = 1'b0;
    bus.alu_wreg_in      = '0;
    bus.alu_result_in    = '0;
    bus.mult_regwrite_in = 1'b0;
    bus.mult_wreg_in     = '0;
    bus.mult_result_in   = '0;
  endtask

  task automatic set_alu(input logic [4:0] r, input logic [31:0] d);
    bus.alu_regwrite_in = 1'b1;
    bus.alu_wreg_in     = r;
    bus.alu_result_in   = d;
  endtask

  task automatic set_mult(input logic [4:0] r, input logic [31:0] d);
    bus.mult_regwrite_in = 1'b1;
    bus.mult_wreg_in     = r;
    bus.mult_result_in   = d;
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.rd_addr_a = 5'd0;
    bus.rd_addr_b = 5'd0;
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus.rf_wdata); end
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow_err); end
    checks++; if (bus.mult_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.mult_stall); end
    checks++; if ({bus.hazard_a, bus.hazard_b} !== 2'b00) begin errors++; $display("FAIL reset_hazard got=%b%b exp=00", bus.hazard_a, bus.hazard_b); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu_only();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      set_alu(5'd3, 32'h11);
      tick();
      checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd3, 32'h11})
        begin errors++; $display("FAIL alu_only_%0d got we=%b a=%0d d=%h exp we=1 a=3 d=11", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
      checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL alu_only_count_%0d got=%0d exp=0", i, dut.u_fifo.count); end
    end
    idle_inputs();
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_only_idle got=%b exp=0", bus.rf_we); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    bus.rd_addr_a = 5'd6;
    set_mult(5'd5, 32'hAA);
    tick();
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'hAA})
      begin errors++; $display("FAIL bypass_r5 got we=%b a=%0d d=%h exp we=1 a=5 d=aa", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL bypass_count0 got=%0d exp=0", dut.u_fifo.count); end
    idle_inputs();
    set_mult(5'd6, 32'hBB);
    set_alu(5'd7, 32'h01);
    tick();
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 32'h01})
      begin errors++; $display("FAIL bypass_r7 got we=%b a=%0d d=%h exp we=1 a=7 d=1", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (dut.u_fifo.count !== 3'd1) begin errors++; $display("FAIL bypass_count1 got=%0d exp=1", dut.u_fifo.count); end
    checks++; if (bus.hazard_a !== 1'b1) begin errors++; $display("FAIL bypass_hazard_set got=%b exp=1", bus.hazard_a); end
    idle_inputs();
    tick();
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd6, 32'hBB})
      begin errors++; $display("FAIL bypass_r6 got we=%b a=%0d d=%h exp we=1 a=6 d=bb", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.hazard_a !== 1'b0) begin errors++; $display("FAIL bypass_hazard_clr got=%b exp=0", bus.hazard_a); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL bypass_count_end got=%0d exp=0", dut.u_fifo.count); end
  endtask

  task automatic test_waw();
    idle_inputs();
    bus.rd_addr_a = 5'd8;
    set_alu(5'd1, 32'h44);
    set_mult(5'd8, 32'h22);
    tick();
    checks++; if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'd1}) begin errors++; $display("FAIL waw_alu1 got we=%b a=%0d exp we=1 a=1", bus.rf_we, bus.rf_waddr); end
    checks++; if (bus.hazard_a !== 1'b1) begin errors++; $display("FAIL waw_hazard_set got=%b exp=1", bus.hazard_a); end
    idle_inputs();
    set_alu(5'd8, 32'h33);
    tick();
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd8, 32'h33})
      begin errors++; $display("FAIL waw_r8 got we=%b a=%0d d=%h exp we=1 a=8 d=33", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.hazard_a !== 1'b0) begin errors++; $display("FAIL waw_killed_hazard got=%b exp=0", bus.hazard_a); end
    checks++; if (dut.u_fifo.count !== 3'd1) begin errors++; $display("FAIL waw_dead_count got=%0d exp=1", dut.u_fifo.count); end
    idle_inputs();
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL waw_silent_pop got we=%b a=%0d exp we=0", bus.rf_we, bus.rf_waddr); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL waw_pop_count got=%0d exp=0", dut.u_fifo.count); end
    set_alu(5'd9, 32'h55);
    set_mult(5'd9, 32'h66);
    tick();
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd9, 32'h55})
      begin errors++; $display("FAIL waw_same_cycle got we=%b a=%0d d=%h exp we=1 a=9 d=55", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL waw_same_count got=%0d exp=0", dut.u_fifo.count); end
    idle_inputs();
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL waw_same_after got we=%b a=%0d exp we=0", bus.rf_we, bus.rf_waddr); end
  endtask

  task automatic test_fill();
    bus.rd_addr_a = 5'd12;
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      set_alu(5'd1, 32'(k));
      set_mult(5'(10 + k), 32'hC0 + 32'(k));
      tick();
      checks++; if (dut.u_fifo.count !== 3'(k + 1)) begin errors++; $display("FAIL fill_count_%0d got=%0d exp=%0d", k, dut.u_fifo.count, k + 1); end
      checks++; if (bus.mult_stall !== (k >= 2)) begin errors++; $display("FAIL fill_stall_%0d got=%b exp=%b", k, bus.mult_stall, (k >= 2)); end
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL fill_ovf_%0d got=%b exp=0", k, bus.overflow_err); end
    end
    checks++; if (bus.hazard_a !== 1'b1) begin errors++; $display("FAIL fill_hazard got=%b exp=1", bus.hazard_a); end
    idle_inputs();
    set_alu(5'd1, 32'h9);
    set_mult(5'd14, 32'hC4);
    tick();
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", bus.overflow_err); end
    checks++; if (dut.u_fifo.count !== 3'd4) begin errors++; $display("FAIL fill_full_count got=%0d exp=4", dut.u_fifo.count); end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'(10 + k), 32'hC0 + 32'(k)})
        begin errors++; $display("FAIL fill_drain_%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, 10 + k, 32'hC0 + k); end
      checks++; if (dut.u_fifo.count !== 3'(3 - k)) begin errors++; $display("FAIL fill_drain_count_%0d got=%0d exp=%0d", k, dut.u_fifo.count, 3 - k); end
    end
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL fill_no_fifth got we=%b a=%0d exp we=0", bus.rf_we, bus.rf_waddr); end
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL fill_ovf_sticky got=%b exp=1", bus.overflow_err); end
    checks++; if (bus.mult_stall !== 1'b0) begin errors++; $display("FAIL fill_stall_clr got=%b exp=0", bus.mult_stall); end
  endtask

  task automatic test_reg0();
    idle_inputs();
    bus.rd_addr_a = 5'd0;
    set_alu(5'd0, 32'h77);
    set_mult(5'd0, 32'h88);
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reg0_both got we=%b exp=0", bus.rf_we); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL reg0_count got=%0d exp=0", dut.u_fifo.count); end
    checks++; if (bus.hazard_a !== 1'b0) begin errors++; $display("FAIL reg0_hazard got=%b exp=0", bus.hazard_a); end
    idle_inputs();
    set_alu(5'd2, 32'h1);
    set_mult(5'd0, 32'h99);
    tick();
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL reg0_mult_buf got=%0d exp=0", dut.u_fifo.count); end
    idle_inputs();
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reg0_after got we=%b exp=0", bus.rf_we); end
  endtask

  task automatic test_reset_mid_drain();
    bus.rd_addr_a = 5'd21;
    bus.rd_addr_b = 5'd22;
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      set_alu(5'd1, 32'h5);
      set_mult(5'(20 + k), 32'hD0 + 32'(k));
      tick();
    end
    idle_inputs();
    tick();
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd20, 32'hD0})
      begin errors++; $display("FAIL rst_drain_first got we=%b a=%0d d=%h exp we=1 a=20 d=d0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (dut.u_fifo.count !== 3'd2) begin errors++; $display("FAIL rst_pre_count got=%0d exp=2", dut.u_fifo.count); end
    checks++; if ({bus.hazard_a, bus.hazard_b} !== 2'b11) begin errors++; $display("FAIL rst_pre_hazard got=%b%b exp=11", bus.hazard_a, bus.hazard_b); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd0, 32'd0})
      begin errors++; $display("FAIL rst_async_rf got we=%b a=%0d d=%h exp 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if ({bus.hazard_a, bus.hazard_b, bus.mult_stall, bus.overflow_err} !== 4'b0000)
      begin errors++; $display("FAIL rst_async_flags got=%b%b%b%b exp=0000", bus.hazard_a, bus.hazard_b, bus.mult_stall, bus.overflow_err); end
    checks++; if (dut.u_fifo.count !== 3'd0) begin errors++; $display("FAIL rst_async_count got=%0d exp=0", dut.u_fifo.count); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_no_write_%0d got we=%b a=%0d exp we=0", k, bus.rf_we, bus.rf_waddr); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu_only();
    test_bypass();
    test_waw();
    test_fill();
    test_reg0();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
